// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state, widths and function-code limits for the ALU subsystem
package alu_pkg;
  localparam int FUNC_W = 5;
  localparam int STATUS_W = 6;
  localparam logic [FUNC_W-1:0] F_LAST = 5'd31;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues commands or 32-op sweeps to the ALU and returns registered results
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int Width = 16,
  parameter int CARRY_BIT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [Width-1:0]    cmd_a_i,
  input  logic [Width-1:0]    cmd_b_i,
  input  logic                cmd_cin_i,
  input  logic                cmd_chain_i,
  input  logic [FUNC_W-1:0]   cmd_f_i,
  input  logic                sweep_start_i,
  output logic                sweep_busy_o,
  output logic [Width-1:0]    alu_a_o,
  output logic [Width-1:0]    alu_b_o,
  output logic                alu_cin_o,
  output logic [FUNC_W-1:0]   alu_f_o,
  input  logic [Width-1:0]    alu_out_i,
  input  logic [STATUS_W-1:0] alu_status_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [Width-1:0]    res_out_o,
  output logic [STATUS_W-1:0] res_status_o,
  output logic [15:0]         op_count_o
);
  state_e                state_q;
  logic [Width-1:0]      alu_a_q, alu_b_q, res_out_q;
  logic [FUNC_W-1:0]     alu_f_q;
  logic [STATUS_W-1:0]   res_status_q;
  logic                  alu_cin_q, sweep_q, carry_q;
  logic [15:0]           op_count_q;
  assign cmd_ready_o  = (state_q == IDLE) && !sweep_start_i;
  assign res_valid_o  = state_q == RESP;
  assign sweep_busy_o = sweep_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_cin_o    = alu_cin_q;
  assign alu_f_o      = alu_f_q;
  assign res_out_o    = res_out_q;
  assign res_status_o = res_status_q;
  assign op_count_o   = op_count_q;
  // issue -> settle -> respond; a sweep loops RESP->EXEC until the last function code
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      alu_f_q      <= '0;
      sweep_q      <= 1'b0;
      res_out_q    <= '0;
      res_status_q <= '0;
      carry_q      <= 1'b0;
      op_count_q   <= '0;
    end else
      case (state_q)
        IDLE:
          if (sweep_start_i) begin
            alu_a_q   <= cmd_a_i;
            alu_b_q   <= cmd_b_i;
            alu_cin_q <= cmd_cin_i;
            alu_f_q   <= '0;
            sweep_q   <= 1'b1;
            state_q   <= EXEC;
          end else if (cmd_valid_i) begin
            alu_a_q   <= cmd_a_i;
            alu_b_q   <= cmd_b_i;
            alu_cin_q <= cmd_chain_i ? carry_q : cmd_cin_i;
            alu_f_q   <= cmd_f_i;
            state_q   <= EXEC;
          end
        EXEC: begin
          res_out_q    <= alu_out_i;
          res_status_q <= alu_status_i;
          carry_q      <= alu_status_i[CARRY_BIT];
          state_q      <= RESP;
        end
        RESP:
          if (res_ready_i) begin
            op_count_q <= op_count_q + 16'd1;
            if (sweep_q && alu_f_q != F_LAST) begin
              alu_f_q <= alu_f_q + 1'b1;
              state_q <= EXEC;
            end else begin
              sweep_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized self-checking bench against an adder-stub ALU and an arithmetic model
module tb_alu_issue_ctrl;
  import alu_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_cin, cmd_chain, sweep_start, sweep_busy;
  logic        alu_cin, res_valid, res_ready;
  logic [15:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, res_out, op_count;
  logic [4:0]  cmd_f, alu_f;
  logic [5:0]  alu_status, res_status;
  int          n_tests = 0, n_fail = 0, m_count = 0;
  logic        m_carry = 1'b0;

  always #5 clk = ~clk;

  assign {alu_status[0], alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
  assign alu_status[5:1] = '0;

  alu_issue_ctrl #(.Width(16), .CARRY_BIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_cin_i(cmd_cin), .cmd_chain_i(cmd_chain), .cmd_f_i(cmd_f),
    .sweep_start_i(sweep_start), .sweep_busy_o(sweep_busy),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin), .alu_f_o(alu_f),
    .alu_out_i(alu_out), .alu_status_i(alu_status),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_out_o(res_out), .res_status_o(res_status), .op_count_o(op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic chain, input logic [4:0] f, input int stall);
    logic        ce;
    logic [16:0] sum;
    ce  = chain ? m_carry : cin;
    sum = {1'b0, a} + {1'b0, b} + {16'd0, ce};
    check("idle_ready", cmd_ready, 1);
    cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_chain = chain; cmd_f = f;
    cmd_valid = 1'b1; res_ready = 1'b0;
    tick;
    cmd_valid = 1'b0;
    check("issue_a", alu_a, a);
    check("issue_b", alu_b, b);
    check("issue_f", alu_f, f);
    check("issue_cin", alu_cin, ce);
    check("exec_nvalid", res_valid, 0);
    tick;
    check("res_valid", res_valid, 1);
    check("res_out", res_out, sum[15:0]);
    check("res_status", res_status, {5'd0, sum[16]});
    m_carry = sum[16];
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      tick;
      check("stall_valid", res_valid, 1);
      check("stall_out", res_out, sum[15:0]);
      check("stall_ready", cmd_ready, 0);
      check("stall_count", op_count, m_count);
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    m_count = (m_count + 1) % 65536;
    check("op_count", op_count, m_count);
    check("done_nvalid", res_valid, 0);
  endtask

  task automatic do_sweep(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_chain = 1'b1; cmd_f = 5'd7;
    cmd_valid = 1'b1; sweep_start = 1'b1;
    #1;
    check("prio_ready", cmd_ready, 0);
    tick;
    sweep_start = 1'b0;
    for (int f = 0; f < 32; f++) begin
      check("sw_f", alu_f, f);
      check("sw_a", alu_a, a);
      check("sw_b", alu_b, b);
      check("sw_cin", alu_cin, cin);
      check("sw_busy", sweep_busy, 1);
      check("sw_ready", cmd_ready, 0);
      tick;
      check("sw_valid", res_valid, 1);
      check("sw_out", res_out, sum[15:0]);
      check("sw_status", res_status, {5'd0, sum[16]});
      res_ready = 1'b1;
      if (f == 31) cmd_valid = 1'b0;
      tick;
      res_ready = 1'b0;
      m_count = (m_count + 1) % 65536;
    end
    m_carry = sum[16];
    check("sw_end_busy", sweep_busy, 0);
    check("sw_end_count", op_count, m_count);
    check("sw_end_valid", res_valid, 0);
    check("sw_end_ready", cmd_ready, 1);
  endtask

  initial begin
    cmd_valid = 0; cmd_cin = 0; cmd_chain = 0; sweep_start = 0; res_ready = 0;
    cmd_a = 0; cmd_b = 0; cmd_f = 0;
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_out", res_out, 0);
    check("rst_status", res_status, 0);
    check("rst_alu", {alu_a, alu_b, alu_cin, alu_f}, 0);
    check("rst_busy", sweep_busy, 0);
    check("rst_count", op_count, 0);
    #11 rst_n = 1'b1;
    tick;
    do_op(16'h0003, 16'h0004, 1'b1, 1'b0, 5'd2, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 5'd0, 0);
    do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 5'd0, 0);
    do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 5'($urandom), 10);
    do_sweep(16'h1234, 16'h0001, 1'b0);
    for (int k = 0; k < 30; k++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
            int'($urandom_range(0, 3)));
    do_sweep(16'($urandom), 16'($urandom), 1'($urandom));
    do_op(16'($urandom), 16'($urandom), 1'b0, 1'b1, 5'd3, 1);
    cmd_a = 16'hFFFF; cmd_b = 16'h0001; cmd_cin = 1'b0; cmd_chain = 1'b0; cmd_f = 5'd9;
    cmd_valid = 1'b1; res_ready = 1'b0;
    tick;
    cmd_valid = 1'b0;
    tick;
    check("pre_rst_valid", res_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", res_valid, 0);
    check("arst_busy", sweep_busy, 0);
    check("arst_count", op_count, 0);
    check("arst_alu", {alu_a, alu_b, alu_cin, alu_f}, 0);
    check("arst_out", res_out, 0);
    m_carry = 1'b0;
    m_count = 0;
    #2 rst_n = 1'b1;
    tick;
    check("post_rst_ready", cmd_ready, 1);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b1, 5'd4, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential initiator for the combinational ALU. It accepts operation commands over a valid/ready handshake and drives the ALU operand/function ports. One cycle later it registers the ALU result and status, then returns them over a second valid/ready handshake. It can also sweep all 32 function codes over one operand pair, and can chain carry between operations. It sits between the instruction/test front end and the ALU instance in the ALU subsystem top.

## Interface
Parameters:
- Width, 16, operand/result width; must match the ALU instance
- CARRY_BIT, 0, index within the ALU status of the carry-out flag

Ports (reset is asynchronous, active-low):
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_a, cmd_b  in  Width  operands
- cmd_cin  in  1  carry-in
- cmd_chain  in  1  1 = use stored carry instead of cmd_cin
- cmd_f  in  5  function code
- sweep_start  in  1  pulse; start a 32-op sweep using cmd_a/cmd_b/cmd_cin
- sweep_busy  out  1  sweep in progress
- alu_a, alu_b  out  Width  to ALU A/B (registered)
- alu_cin  out  1  to ALU Cin (registered)
- alu_f  out  5  to ALU F (registered)
- alu_out  in  Width  from ALU Out
- alu_status  in  6  from ALU Status
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid && res_ready at a rising edge
- res_out  out  Width  captured result
- res_status  out  6  captured status
- op_count  out  16  completed result handshakes, wraps modulo 2^16

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = !sweep_start (combinational); all other handshake outputs low.
  - sweep_start=1: latch cmd_a/cmd_b/cmd_cin into alu_*, alu_f=0, sweep_busy=1, go EXEC. sweep_start wins over a simultaneous cmd_valid, and that command is not accepted.
  - Else cmd_valid=1: latch alu_a=cmd_a, alu_b=cmd_b, alu_f=cmd_f, alu_cin = cmd_chain ? carry_q : cmd_cin; go EXEC.
- EXEC: one settle cycle for the ALU. At the closing edge:
  - res_out←alu_out, res_status←alu_status, carry_q←alu_status[CARRY_BIT];
  - go RESP.
- RESP:
  - res_valid=1; res_out/res_status held stable until the handshake.
  - On handshake: op_count+1. If sweep_busy and alu_f≠31: alu_f+1, go EXEC. If sweep_busy and alu_f=31: sweep_busy←0, go IDLE. Otherwise go IDLE.
- alu_a/alu_b/alu_cin/alu_f stay constant from issue until the next issue. Sweep keeps the latched A, B and Cin for all 32 ops; chaining does not apply during a sweep.
- sweep_start outside IDLE is ignored.
- cmd_chain with no prior result uses carry_q=0.

## Timing
- Reset values: cmd_ready=1 after deassertion (IDLE); res_valid=0; res_out=0; res_status=0; alu_a=alu_b=0; alu_cin=0; alu_f=0; sweep_busy=0; op_count=0; carry_q=0.
- Reset mid-operation aborts immediately; any pending result is lost.
- Command accepted at edge N:
  - alu_* valid after N;
  - result captured at N+1;
  - res_valid high from N+1.
- Minimum spacing is 3 cycles per single op with res_ready tied high. In a sweep it is 2 cycles per op, so 64 cycles for the full sweep.
- res_ready low stalls indefinitely in RESP with outputs frozen; no new command is accepted.
- op_count wraps 0xFFFF→0x0000.

## Structure
- Shared package alu_pkg:
  - state enum {IDLE, EXEC, RESP};
  - FUNC_W=5, STATUS_W=6, F_LAST=5'd31.
  - The ALU testbench and subsystem top also import alu_pkg.
- No sub-module. The ALU is instantiated beside this block in alu_subsys_top.
- Single FSM plus operand, result, carry and counter registers.

## Test plan
Bench uses an ALU stub: Out = A + B + Cin, Status[0] = carry.
- Single op: a=0x0003, b=0x0004, cin=1, f=2 → alu_f=2; res_valid at N+1; res_out=0x0008, res_status[0]=0; op_count=1.
- Carry chain:
  - op1: a=0xFFFF, b=0x0001, cin=0 → res_out=0x0000, carry=1.
  - op2: a=0, b=0, cmd_chain=1 → alu_cin=1, res_out=0x0001.
- Backpressure: res_ready low for 10 cycles → res_valid held, res_out stable, cmd_ready=0. Release → one handshake, op_count +1 only.
- Sweep: sweep_start with a=0x1234, b=0x0001 → 32 results, alu_f 0..31 in order; sweep_busy falls after the f=31 handshake; op_count=32; 64 cycles with res_ready=1.
- Priority: sweep_start and cmd_valid in the same IDLE cycle → sweep runs, cmd not accepted. cmd_valid during the sweep → cmd_ready=0 throughout.
- Reset mid-RESP: rst_n low asynchronously → res_valid=0, sweep_busy=0, op_count=0, carry_q=0, alu_*=0 immediately. cmd_ready=1 after release.
